// File: rtl/alu_board_ctrl_if.sv
// rtl/alu_board_ctrl_if.sv - operand/result bundle between the board controller and the ALU
interface alu_board_ctrl_if;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic        alu_cf;
    logic        alu_vf;
    logic        alu_sco;
    logic [31:0] alu_f;
    logic [3:0]  alu_nzcv;

    modport master (
        output alu_a, alu_b, alu_op, alu_cf, alu_vf, alu_sco,
        input  alu_f, alu_nzcv
    );

    modport slave (
        input  alu_a, alu_b, alu_op, alu_cf, alu_vf, alu_sco,
        output alu_f, alu_nzcv
    );
endinterface

// File: rtl/alu_board_ctrl.sv
// rtl/alu_board_ctrl.sv - button/switch sequencer for the 32-bit ALU; ALU_CTRL_AUTOEXEC_EN makes every load also execute
module alu_board_ctrl #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
    parameter logic [3:0]  SETTLE_CYCLES   = 4'd2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             sw,
    input  logic [4:0]              btn,
    alu_board_ctrl_if.master        alu,
    output logic [31:0]             result,
    output logic [3:0]              nzcv,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              disp_sel,
    output logic [31:0]             disp_data
);
    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

    state_t            state, state_nx;
    logic [3:0]        settle_cnt, settle_cnt_nx;
    logic [4:0]        sync1, sync2, stable, stable_d, pulse;
    logic [4:0][19:0]  db_cnt;
    logic              idle, ld_a, ld_b, ld_op, go, start;

    // Synchronize, debounce and edge-detect all five buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            pulse    <= '0;
            db_cnt   <= '0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            stable_d <= stable;
            pulse    <= stable & ~stable_d;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DEBOUNCE_CYCLES - 20'd1) begin
                    db_cnt[i] <= '0;
                    stable[i] <= ~stable[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 20'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
        end else begin
            state      <= state_nx;
            settle_cnt <= settle_cnt_nx;
        end
    end

    // Lower-numbered buttons win; anything arriving mid-sequence is dropped.
    always_comb begin
        idle          = (state == IDLE);
        ld_a          = idle && pulse[0];
        ld_b          = idle && (pulse[1:0] == 2'b10);
        ld_op         = idle && (pulse[2:0] == 3'b100);
        go            = idle && (pulse[3:0] == 4'b1000);
`ifdef ALU_CTRL_AUTOEXEC_EN
        start         = go || ld_a || ld_b || ld_op;
`else
        start         = go;
`endif
        state_nx      = state;
        settle_cnt_nx = settle_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx      = SETTLE;
                    settle_cnt_nx = SETTLE_CYCLES;
                end
            end
            SETTLE: begin
                if (settle_cnt <= 4'd1) begin
                    state_nx = CAPTURE;
                end else begin
                    settle_cnt_nx = settle_cnt - 4'd1;
                end
            end
            CAPTURE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

`ifdef ALU_CTRL_AUTOEXEC_EN
    logic auto_seq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_seq <= 1'b0;
        end else if (idle && start) begin
            auto_seq <= !go;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu.alu_a   <= '0;
            alu.alu_b   <= '0;
            alu.alu_op  <= '0;
            alu.alu_cf  <= 1'b0;
            alu.alu_vf  <= 1'b0;
            alu.alu_sco <= 1'b0;
            result      <= '0;
            nzcv        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            disp_sel    <= '0;
            disp_data   <= '0;
        end else begin
            busy <= (state_nx != IDLE);
            done <= (state == CAPTURE);
            if (ld_a) alu.alu_a <= sw;
            if (ld_b) alu.alu_b <= sw;
            if (ld_op) begin
                alu.alu_op  <= sw[31:28];
                alu.alu_cf  <= sw[27];
                alu.alu_vf  <= sw[26];
                alu.alu_sco <= sw[25];
            end
            if (state == CAPTURE) begin
                result <= alu.alu_f;
                nzcv   <= alu.alu_nzcv;
            end
`ifdef ALU_CTRL_AUTOEXEC_EN
            if (state == CAPTURE && auto_seq) begin
                disp_sel <= 2'd2;
            end else
`endif
            if (pulse[4]) begin
                disp_sel <= (disp_sel == 2'd2) ? 2'd0 : disp_sel + 2'd1;
            end
            case (disp_sel)
                2'd0:    disp_data <= alu.alu_a;
                2'd1:    disp_data <= alu.alu_b;
                default: disp_data <= result;
            endcase
        end
    end
endmodule
